int_ctrl: RTL and testbench

Parametrised multi-channel interrupt controller for the 5-stage pipelined CPU. It replaces the single raw `INT` line with N prioritised, maskable, edge- or level-sensitive request channels. It decides when to take an interrupt against the EX-stage instruction, captures SEPC and a cause code, supplies a vectored handler address to next-PC selection, and holds in-service state until `eret` retires in EX.

---
 rtl/int_ctrl_if.sv | 31 +++
 rtl/int_ctrl.sv | 144 ++++++++++++++
 tb/tb_int_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_ctrl_if.sv
// Request/response bundle between the interrupt controller and the CPU pipeline.
// The slave modport is the controller's view; the master modport drives requests and control.
interface int_ctrl_if #(
    parameter int N_IRQ = 4
);
    logic [N_IRQ-1:0] irq_in;
    logic             mask_we;
    logic [N_IRQ-1:0] mask_wdata;
    logic [N_IRQ-1:0] pend_clr;
    logic             stall;
    logic             ex_valid;
    logic [31:0]      ex_pc;
    logic             eret;
    logic             int_req;
    logic [31:0]      int_vec;
    logic [31:0]      sepc;
    logic [31:0]      cause;
    logic [4:0]       int_id;
    logic             in_service;
    logic [N_IRQ-1:0] pending;

    modport slave (
        input  irq_in, mask_we, mask_wdata, pend_clr, stall, ex_valid, ex_pc, eret,
        output int_req, int_vec, sepc, cause, int_id, in_service, pending
    );

    modport master (
        output irq_in, mask_we, mask_wdata, pend_clr, stall, ex_valid, ex_pc, eret,
        input  int_req, int_vec, sepc, cause, int_id, in_service, pending
    );
endinterface

// File: rtl/int_ctrl.sv
// Multi-channel prioritised interrupt controller: per-channel pending capture,
// lowest-index arbitration, take/eret FSM and SEPC/cause capture for the EX stage.

module int_ctrl_chan #(
    parameter bit EDGE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    input  logic clr,
    input  logic take,
    output logic pend
);
    logic irq_d_q;
    logic pend_q, pend_d;

    // A fresh rising edge beats both a software clear and the take of this channel.
    always_comb begin
        pend_d = pend_q;
        if (EDGE) begin
            if (clr || take) pend_d = 1'b0;
            if (irq && !irq_d_q) pend_d = 1'b1;
        end else begin
            pend_d = irq;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_d_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            irq_d_q <= irq;
            pend_q  <= pend_d;
        end
    end

    assign pend = pend_q;
endmodule

module int_ctrl #(
    parameter int               N_IRQ     = 4,
    parameter logic [N_IRQ-1:0] EDGE_MASK = {N_IRQ{1'b1}},
    parameter logic [N_IRQ-1:0] MASK_RST  = {N_IRQ{1'b1}},
    parameter bit               VECTORED  = 1'b1,
    parameter logic [31:0]      VEC_BASE  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    int_ctrl_if.slave   bus
);
    typedef enum logic {IDLE, SERVICE} state_e;

    state_e           state_q, state_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [31:0]      sepc_q, sepc_d;
    logic [31:0]      cause_q, cause_d;
    logic [4:0]       int_id_q, int_id_d;

    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] enabled;
    logic [N_IRQ-1:0] take_vec;
    logic [4:0]       winner;
    logic             int_req;

    genvar g;
    generate
        for (g = 0; g < N_IRQ; g++) begin : g_chan
            int_ctrl_chan #(.EDGE(EDGE_MASK[g])) u_chan (
                .clk  (clk),
                .rst  (rst),
                .irq  (bus.irq_in[g]),
                .clr  (bus.pend_clr[g]),
                .take (take_vec[g]),
                .pend (pending[g])
            );
            assign take_vec[g] = int_req && (winner == 5'(g));
        end
    endgenerate

    assign enabled = pending & mask_q;

    // Scan high to low so the lowest enabled index is the one left standing.
    always_comb begin
        winner = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (enabled[i]) winner = 5'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        int_req = 1'b0;
        case (state_q)
            IDLE: begin
                if ((|enabled) && !bus.stall && bus.ex_valid) begin
                    int_req = 1'b1;
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (bus.eret && !bus.stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The take decision above reads mask_q, so a same-cycle mask write only affects later cycles.
    always_comb begin
        mask_d   = bus.mask_we ? bus.mask_wdata : mask_q;
        sepc_d   = sepc_q;
        cause_d  = cause_q;
        int_id_d = int_id_q;
        if (int_req) begin
            sepc_d   = bus.ex_pc;
            cause_d  = {1'b1, 26'd0, winner};
            int_id_d = winner;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            mask_q   <= MASK_RST;
            sepc_q   <= '0;
            cause_q  <= '0;
            int_id_q <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            sepc_q   <= sepc_d;
            cause_q  <= cause_d;
            int_id_q <= int_id_d;
        end
    end

    assign bus.int_req    = int_req;
    assign bus.int_vec    = VECTORED ? (VEC_BASE + {25'd0, winner, 2'b00}) : VEC_BASE;
    assign bus.sepc       = sepc_q;
    assign bus.cause      = cause_q;
    assign bus.int_id     = int_id_q;
    assign bus.in_service = (state_q == SERVICE);
    assign bus.pending    = pending;
endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: expected takes are queued when stimulus is driven
// and retired by a monitor whenever int_req fires on the vectored instance.
module tb_int_ctrl;
    logic clk;
    logic rst;

    int_ctrl_if #(.N_IRQ(4)) m ();
    int_ctrl_if #(.N_IRQ(4)) l ();

    int_ctrl #(.N_IRQ(4)) u_dut (.clk(clk), .rst(rst), .bus(m));

    int_ctrl #(
        .N_IRQ(4), .EDGE_MASK(4'b0111), .MASK_RST(4'b1111),
        .VECTORED(1'b0), .VEC_BASE(32'h0000_0100)
    ) u_lvl (.clk(clk), .rst(rst), .bus(l));

    typedef struct {
        logic [31:0] vec;
        logic [31:0] pc;
        logic [31:0] cause;
    } exp_t;

    exp_t sb[$];
    exp_t exp_last;
    bit   chk_after;
    int   checks, errors, n_takes, n_pushed;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_take(input logic [31:0] vec, input logic [31:0] pc, input logic [4:0] id);
        exp_t e;
        e.vec   = vec;
        e.pc    = pc;
        e.cause = {1'b1, 26'd0, id};
        sb.push_back(e);
        n_pushed++;
    endtask

    // Retire one queued take per int_req cycle; captured state is checked one cycle later.
    always @(negedge clk) begin
        if (chk_after) begin
            chk("sepc", m.sepc, exp_last.pc);
            chk("cause", m.cause, exp_last.cause);
            chk("int_id", {27'd0, m.int_id}, {27'd0, exp_last.cause[4:0]});
            chk("in_service_after_take", {31'd0, m.in_service}, 32'd1);
            chk_after = 1'b0;
        end
        if (m.int_req === 1'b1) begin
            n_takes++;
            checks++;
            assert (sb.size() != 0)
            else begin
                errors++;
                $error("FAIL unexpected_int_req observed=int_req expected=no_take_queued");
            end
            if (sb.size() != 0) begin
                exp_last = sb.pop_front();
                chk("int_vec", m.int_vec, exp_last.vec);
                chk_after = 1'b1;
            end
        end
    end

    initial begin
        rst = 1'b0;
        m.irq_in = '0; m.mask_we = 1'b0; m.mask_wdata = '0; m.pend_clr = '0;
        m.stall = 1'b0; m.ex_valid = 1'b1; m.ex_pc = '0; m.eret = 1'b0;
        l.irq_in = '0; l.mask_we = 1'b0; l.mask_wdata = '0; l.pend_clr = '0;
        l.stall = 1'b0; l.ex_valid = 1'b1; l.ex_pc = '0; l.eret = 1'b0;

        #2;
        chk("rst_int_req", {31'd0, m.int_req}, 32'd0);
        chk("rst_in_service", {31'd0, m.in_service}, 32'd0);
        chk("rst_int_vec", m.int_vec, 32'h100);
        chk("rst_pending", {28'd0, m.pending}, 32'd0);
        chk("rst_sepc", m.sepc, 32'd0);
        chk("rst_cause", m.cause, 32'd0);
        #10 rst = 1'b1;
        step();

        // single edge pulse on channel 1
        m.irq_in = 4'b0010; m.ex_pc = 32'h40;
        expect_take(32'h104, 32'h40, 5'd1);
        step();
        m.irq_in = '0;
        chk("t1_pending_set", {28'd0, m.pending}, 32'h2);
        chk("t1_int_req", {31'd0, m.int_req}, 32'd1);
        step();
        chk("t1_req_pulse", {31'd0, m.int_req}, 32'd0);
        chk("t1_pending_clr", {28'd0, m.pending}, 32'd0);
        chk("t1_in_service", {31'd0, m.in_service}, 32'd1);
        step();
        chk("t1_takes", n_takes, 32'd1);
        m.eret = 1'b1;
        step();
        m.eret = 1'b0;
        chk("t1_eret_idle", {31'd0, m.in_service}, 32'd0);

        // channels 0 and 2 together: 0 first, 2 after eret
        m.irq_in = 4'b0101; m.ex_pc = 32'h80;
        expect_take(32'h100, 32'h80, 5'd0);
        step();
        m.irq_in = '0;
        step();
        chk("t2_pending_ch2", {28'd0, m.pending}, 32'h4);
        m.ex_pc = 32'h90;
        step();
        m.eret = 1'b1;
        expect_take(32'h108, 32'h90, 5'd2);
        #1 chk("t2_no_req_with_eret", {31'd0, m.int_req}, 32'd0);
        step();
        m.eret = 1'b0;
        #1 chk("t2_req_after_eret", {31'd0, m.int_req}, 32'd1);
        chk("t2_vec_ch2", m.int_vec, 32'h108);
        step();
        chk("t2_pending_empty", {28'd0, m.pending}, 32'd0);
        m.eret = 1'b1;
        step();
        m.eret = 1'b0;

        // stall holds off the take of channel 3
        m.stall = 1'b1; m.irq_in = 4'b1000; m.ex_pc = 32'hA0;
        step();
        m.irq_in = '0;
        for (int i = 0; i < 3; i++) begin
            chk("t3_stall_no_req", {31'd0, m.int_req}, 32'd0);
            chk("t3_stall_pending", {28'd0, m.pending}, 32'h8);
            m.ex_pc = m.ex_pc + 32'd4;
            step();
        end
        m.stall = 1'b0; m.ex_pc = 32'hC0;
        expect_take(32'h10C, 32'hC0, 5'd3);
        #1 chk("t3_req_on_unstall", {31'd0, m.int_req}, 32'd1);
        step();
        m.eret = 1'b1;
        step();
        m.eret = 1'b0;

        // bubble in EX holds off the take
        m.ex_valid = 1'b0; m.irq_in = 4'b0001;
        step();
        m.irq_in = '0;
        chk("t3b_bubble_no_req", {31'd0, m.int_req}, 32'd0);
        step();
        chk("t3b_bubble_no_req2", {31'd0, m.int_req}, 32'd0);
        m.ex_valid = 1'b1; m.ex_pc = 32'hE0;
        expect_take(32'h100, 32'hE0, 5'd0);
        #1 chk("t3b_req_valid", {31'd0, m.int_req}, 32'd1);
        step();
        m.eret = 1'b1;
        step();
        m.eret = 1'b0;

        // masked channel 1, software clear, set-over-clear, old-mask take decision
        m.mask_we = 1'b1; m.mask_wdata = 4'b1101;
        step();
        m.mask_we = 1'b0; m.irq_in = 4'b0010;
        step();
        m.irq_in = '0;
        chk("t4_masked_no_req", {31'd0, m.int_req}, 32'd0);
        chk("t4_masked_pending", {28'd0, m.pending}, 32'h2);
        step();
        m.pend_clr = 4'b0010;
        step();
        m.pend_clr = '0;
        chk("t4_pend_clr", {28'd0, m.pending}, 32'd0);
        m.irq_in = 4'b0010; m.pend_clr = 4'b0010;
        step();
        m.irq_in = '0; m.pend_clr = '0;
        chk("t4_set_wins", {28'd0, m.pending}, 32'h2);
        m.mask_we = 1'b1; m.mask_wdata = 4'b1111; m.ex_pc = 32'h120;
        expect_take(32'h104, 32'h120, 5'd1);
        #1 chk("t4_old_mask_no_req", {31'd0, m.int_req}, 32'd0);
        step();
        m.mask_we = 1'b0;
        #1 chk("t4_new_mask_req", {31'd0, m.int_req}, 32'd1);
        step();
        m.eret = 1'b1;
        step();
        m.eret = 1'b0;

        // level channel 3 on the non-vectored instance
        l.irq_in = 4'b1000; l.ex_pc = 32'h60;
        step();
        chk("t5_lvl_pending", {28'd0, l.pending}, 32'h8);
        chk("t5_lvl_req", {31'd0, l.int_req}, 32'd1);
        chk("t5_lvl_vec", l.int_vec, 32'h100);
        step();
        chk("t5_lvl_in_service", {31'd0, l.in_service}, 32'd1);
        chk("t5_lvl_id", {27'd0, l.int_id}, 32'd3);
        chk("t5_lvl_cause", l.cause, 32'h8000_0003);
        chk("t5_lvl_no_nest", {31'd0, l.int_req}, 32'd0);
        l.pend_clr = 4'b1000;
        step();
        l.pend_clr = '0;
        chk("t5_lvl_clr_ignored", {28'd0, l.pending}, 32'h8);
        l.eret = 1'b1;
        #1 chk("t5_lvl_no_req_eret", {31'd0, l.int_req}, 32'd0);
        step();
        l.eret = 1'b0;
        chk("t5_lvl_idle", {31'd0, l.in_service}, 32'd0);
        chk("t5_lvl_retake", {31'd0, l.int_req}, 32'd1);
        step();
        chk("t5_lvl_service2", {31'd0, l.in_service}, 32'd1);
        l.irq_in = '0; l.eret = 1'b1;
        step();
        l.eret = 1'b0;
        chk("t5_lvl_done", {31'd0, l.int_req}, 32'd0);

        // asynchronous reset in the middle of service
        m.irq_in = 4'b0100; m.ex_pc = 32'h200;
        expect_take(32'h108, 32'h200, 5'd2);
        step();
        m.irq_in = '0;
        step();
        m.mask_we = 1'b1; m.mask_wdata = 4'b0000;
        step();
        m.mask_we = 1'b0; m.irq_in = 4'b0001;
        step();
        m.irq_in = '0;
        chk("t6_pre_in_service", {31'd0, m.in_service}, 32'd1);
        chk("t6_pre_pending", {28'd0, m.pending}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_in_service", {31'd0, m.in_service}, 32'd0);
        chk("t6_rst_int_req", {31'd0, m.int_req}, 32'd0);
        chk("t6_rst_pending", {28'd0, m.pending}, 32'd0);
        chk("t6_rst_sepc", m.sepc, 32'd0);
        chk("t6_rst_cause", m.cause, 32'd0);
        chk("t6_rst_int_id", {27'd0, m.int_id}, 32'd0);
        chk("t6_rst_int_vec", m.int_vec, 32'h100);
        step();
        rst = 1'b1;
        m.irq_in = 4'b1000; m.ex_pc = 32'h300;
        expect_take(32'h10C, 32'h300, 5'd3);
        step();
        m.irq_in = '0;
        chk("t6_mask_restored_req", {31'd0, m.int_req}, 32'd1);
        step();
        m.eret = 1'b1;
        step();
        m.eret = 1'b0;
        step();

        chk("all_takes_seen", n_takes, n_pushed);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
